glb_blk_stream_framer: RTL and testbench
========================================

// Module: glb_blk_stream_framer
// PURPOSE
//  Upstream feeder for the fiber_access write scanner's block-write input (write_scanner_block_wr_in).
//  Takes a raw 16-bit word stream from the GLB side, where each fiber ends with a last flag.
//  Buffers one fiber, then re-emits it as a 17-bit block stream: a length header, then the payload.
//  In seg mode each transaction is two fibers (seg array, then crd array), each framed with its own header.
// PARAMETERS
//  DATA_W  16   payload width; blk_out is DATA_W+1 bits, bit DATA_W is always 0
//  DEPTH   256  fiber buffer depth in words (power of 2)
//  CNT_W   $clog2(DEPTH+1)  length counter width
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  clk_en         in   1        global clock enable; when 0, all state holds
//  flush          in   1        sync soft reset; same effect as rst_n
//  seg_mode       in   1        1: two fibers per transaction; 0: one fiber per transaction
//  tx_num         in   16       transactions to frame before done; 0 = unlimited
//  in_data        in   DATA_W   raw GLB word
//  in_last        in   1        this beat ends the current fiber
//  in_empty       in   1        with in_last: zero-length fiber, in_data is ignored
//  in_valid       in   1        raw stream valid
//  in_ready       out  1        raw stream ready
//  blk_out        out  DATA_W+1 block stream word (header or payload)
//  blk_out_valid  out  1        block stream valid
//  blk_out_ready  in   1        block stream ready
//  done           out  1        sticky: tx_num transactions fully emitted
//  tx_count       out  16       completed transactions
//  overflow       out  1        sticky: buffer filled before in_last arrived
// BEHAVIOUR
//  Reset/flush values: FSM=IDLE, in_ready=0, blk_out=0, blk_out_valid=0, done=0, tx_count=0, overflow=0.
//   Pointers, len and sub (fiber index) are 0.
//  Handshakes:
//   - A transfer happens on valid&ready at a rising clk edge with clk_en=1.
//   - blk_out and blk_out_valid are registered and held stable until accepted.
//   - blk_out_valid never depends combinationally on blk_out_ready.
//  FSM:
//   IDLE : in_ready=0. Go to FILL the next cycle unless done.
//   FILL : in_ready=1.
//          - Each accepted beat with !in_empty writes buf[wptr] and increments len.
//          - When a beat with in_last is accepted, or len reaches DEPTH, go to HDR.
//          - Reaching DEPTH without in_last sets overflow. The rest of that fiber is then framed as the next
//            fiber; there is no recovery.
//   HDR  : in_ready=0. blk_out={1'b0, len zero-extended}, valid=1.
//          - On accept: go to DRAIN if len>0, else go to NEXT.
//          - The header appears the cycle after the last beat is accepted (1-cycle latency).
//   DRAIN: blk_out={1'b0, buf[rptr]}, emitted in write order, one word per accepted beat.
//          - Back-to-back at full throughput, with no bubble between the header and the first word.
//          - After the len-th word is accepted, go to NEXT.
//   NEXT : (1 cycle)
//          - If seg_mode and sub==0: sub<=1, go to FILL.
//          - Otherwise: sub<=0, tx_count++. If tx_num!=0 and tx_count+1==tx_num, set done and go to IDLE.
//            Else go to FILL.
//  Buffer:
//   - Simple dual-port register array. Pointers wrap modulo DEPTH.
//   - len and pointers reset to 0 at every HDR->FILL/NEXT turn.
//   - Fill and drain never overlap, so there are no simultaneous read/write hazards.
//  Boundaries:
//   - Zero-length fiber: header 0, no payload.
//   - Full-depth fiber (len==DEPTH with in_last on the DEPTH-th beat): header=DEPTH, overflow stays 0.
//   - seg_mode is sampled only in NEXT; changing it mid-fiber has no effect until then.
//   - tx_num changes take effect at the next NEXT.
//   - Reset or flush mid-DRAIN drops the fiber immediately; blk_out_valid is 0 the next cycle.
//   - blk_out_ready held low stalls HDR/DRAIN indefinitely with blk_out stable. in_ready stays 0.
//   - clk_en=0 freezes every register, including done and tx_count.
// TESTING
//  1. seg_mode=0, tx_num=1, fiber {5,9,12}+last, ready=1
//     -> blk_out 3,5,9,12; done=1; tx_count=1
//  2. seg_mode=1, tx_num=1, seg {0,2}, crd {4,7}
//     -> 2,0,2,2,4,7; done after the 6th accept
//  3. Empty crd fiber (in_empty&in_last) in seg_mode
//     -> header 0 with no payload; tx_count increments
//  4. DEPTH=4, 6-word fiber
//     -> header 4 plus 4 words, overflow=1; the next header is 2
//  5. blk_out_ready toggling 1/0 every cycle in DRAIN
//     -> output order intact, blk_out stable while stalled, no duplicates
//  6. rst_n low mid-DRAIN, then refill {1}
//     -> all outputs return to reset values; the next output is 1,1; tx_count starts at 0

Source files
------------

// File: rtl/glb_blk_stream_framer.sv
// glb_blk_stream_framer
// Buffers one raw GLB fiber and re-emits it as a block stream: a length
// header followed by the payload words in arrival order. In seg mode a
// transaction is two fibers (seg then crd), each with its own header.
module glb_blk_stream_framer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              seg_mode,
  input  logic [15:0]       tx_num,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_empty,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W:0]   blk_out,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic              done,
  output logic [15:0]       tx_count,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HDR,
    DRAIN,
    NEXT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  rd_cnt;
  logic              sub;

  logic              in_fire;
  logic              out_fire;
  logic              wr_word;
  logic [CNT_W-1:0]  len_inc;
  logic              len_full;
  logic [CNT_W-1:0]  hdr_len;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = blk_out_valid & blk_out_ready;
  assign wr_word  = in_fire & ~in_empty & (state == FILL);
  assign len_inc  = len + CNT_W'(1);
  assign len_full = (len_inc == CNT_W'(DEPTH));
  assign hdr_len  = in_empty ? len : len_inc;

  // Fiber buffer write port; the array itself carries no reset
  always_ff @(posedge clk) begin
    if (clk_en && !flush && wr_word) begin
      mem[wptr] <= in_data;
    end
  end

  // Framing FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      blk_out       <= '0;
      blk_out_valid <= 1'b0;
      done          <= 1'b0;
      tx_count      <= '0;
      overflow      <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      len           <= '0;
      rd_cnt        <= '0;
      sub           <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      blk_out       <= '0;
      blk_out_valid <= 1'b0;
      done          <= 1'b0;
      tx_count      <= '0;
      overflow      <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      len           <= '0;
      rd_cnt        <= '0;
      sub           <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (!done) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        FILL: begin
          if (in_fire) begin
            if (!in_empty) begin
              wptr <= wptr + PTR_W'(1);
              len  <= len_inc;
            end
            if (in_last || (!in_empty && len_full)) begin
              state         <= HDR;
              in_ready      <= 1'b0;
              blk_out       <= {1'b0, DATA_W'(hdr_len)};
              blk_out_valid <= 1'b1;
              if (!in_last) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        HDR: begin
          if (out_fire) begin
            if (len != '0) begin
              state   <= DRAIN;
              blk_out <= {1'b0, mem[rptr]};
              rptr    <= rptr + PTR_W'(1);
              rd_cnt  <= CNT_W'(1);
            end else begin
              state         <= NEXT;
              blk_out_valid <= 1'b0;
              len           <= '0;
              wptr          <= '0;
              rptr          <= '0;
              rd_cnt        <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_cnt == len) begin
              state         <= NEXT;
              blk_out_valid <= 1'b0;
              len           <= '0;
              wptr          <= '0;
              rptr          <= '0;
              rd_cnt        <= '0;
            end else begin
              blk_out <= {1'b0, mem[rptr]};
              rptr    <= rptr + PTR_W'(1);
              rd_cnt  <= rd_cnt + CNT_W'(1);
            end
          end
        end
        NEXT: begin
          if (seg_mode && !sub) begin
            sub      <= 1'b1;
            state    <= FILL;
            in_ready <= 1'b1;
          end else begin
            sub      <= 1'b0;
            tx_count <= tx_count + 16'd1;
            if ((tx_num != 16'd0) && ((tx_count + 16'd1) == tx_num)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_blk_stream_framer.sv
// tb_glb_blk_stream_framer
// Directed bench for the block stream framer, built with a 4-word buffer so
// that full-depth and overflow fibers stay short.
module tb_glb_blk_stream_framer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              clk_en;
  logic              flush;
  logic              seg_mode;
  logic [15:0]       tx_num;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_empty;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W:0]   blk_out;
  logic              blk_out_valid;
  logic              blk_out_ready;
  logic              done;
  logic [15:0]       tx_count;
  logic              overflow;

  int tests_run;
  int tests_failed;

  glb_blk_stream_framer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .flush        (flush),
    .seg_mode     (seg_mode),
    .tx_num       (tx_num),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .blk_out      (blk_out),
    .blk_out_valid(blk_out_valid),
    .blk_out_ready(blk_out_ready),
    .done         (done),
    .tx_count     (tx_count),
    .overflow     (overflow)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence wedges somewhere unexpected
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_flush;
    @(negedge clk);
    blk_out_ready = 1'b0;
    in_valid      = 1'b0;
    flush         = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input logic empty);
    int waited;
    waited   = 0;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_timeout: data=%0d in_ready=%b, required 1 within 50 cycles", d, in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic recv_word(output logic [DATA_W:0] got, output int waited);
    waited        = 0;
    blk_out_ready = 1'b1;
    while (blk_out_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    got = blk_out;
    if (blk_out_valid === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #22;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready); end
    tests_run++;
    if (blk_out !== 17'd0) begin tests_failed++; $display("[TB] FAIL reset_blk_out: got %0d, required 0", blk_out); end
    tests_run++;
    if (blk_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b, required 0", blk_out_valid); end
    tests_run++;
    if (done !== 1'b0 || overflow !== 1'b0 || tx_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: done=%b overflow=%b tx_count=%0d, required 0 0 0", done, overflow, tx_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_fiber;
    logic [DATA_W:0] exp [4];
    logic [DATA_W:0] got;
    int waited;
    exp = '{17'd3, 17'd5, 17'd9, 17'd12};
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd1;
    send_beat(16'd5, 1'b0, 1'b0);
    send_beat(16'd9, 1'b0, 1'b0);
    send_beat(16'd12, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL single_word%0d: got %0d after %0d waits, required %0d with no wait", i, got, waited, exp[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || tx_count !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_done: done=%b tx_count=%0d, required 1 1", done, tx_count);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || blk_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_idle_after_done: in_ready=%b valid=%b, required 0 0", in_ready, blk_out_valid);
    end
  endtask

  task automatic test_seg_mode;
    logic [DATA_W:0] exp [6];
    logic [DATA_W:0] got;
    int waited;
    exp = '{17'd2, 17'd0, 17'd2, 17'd2, 17'd4, 17'd7};
    do_flush();
    seg_mode = 1'b1;
    tx_num   = 16'd1;
    send_beat(16'd0, 1'b0, 1'b0);
    send_beat(16'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL seg_word%0d: got %0d after %0d waits, required %0d", i, got, waited, exp[i]);
      end
    end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL seg_done_early: got %b, required 0", done); end
    send_beat(16'd4, 1'b0, 1'b0);
    send_beat(16'd7, 1'b1, 1'b0);
    for (int i = 3; i < 6; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL seg_word%0d: got %0d after %0d waits, required %0d", i, got, waited, exp[i]);
      end
    end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL seg_done_at_last_accept: got %b, required 0", done); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || tx_count !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL seg_done: done=%b tx_count=%0d, required 1 1", done, tx_count);
    end
  endtask

  task automatic test_empty_crd;
    logic [DATA_W:0] got;
    int waited;
    do_flush();
    seg_mode = 1'b1;
    tx_num   = 16'd0;
    send_beat(16'd3, 1'b1, 1'b0);
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd1 || waited != 0) begin tests_failed++; $display("[TB] FAIL empty_seg_hdr: got %0d, required 1", got); end
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd3 || waited != 0) begin tests_failed++; $display("[TB] FAIL empty_seg_word: got %0d, required 3", got); end
    send_beat(16'hffff, 1'b1, 1'b1);
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd0 || waited != 0) begin tests_failed++; $display("[TB] FAIL empty_crd_hdr: got %0d, required 0", got); end
    tests_run++;
    if (blk_out_valid !== 1'b0 || tx_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL empty_crd_no_payload: valid=%b tx_count=%0d, required 0 0", blk_out_valid, tx_count);
    end
    @(negedge clk);
    tests_run++;
    if (tx_count !== 16'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL empty_crd_count: tx_count=%0d in_ready=%b, required 1 1", tx_count, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [DATA_W:0] exp [8];
    logic [DATA_W:0] got;
    int waited;
    exp = '{17'd4, 17'd10, 17'd11, 17'd12, 17'd13, 17'd2, 17'd14, 17'd15};
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd0;
    for (int i = 0; i < 4; i++) send_beat(16'(10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL ovf_word%0d: got %0d after %0d waits, required %0d", i, got, waited, exp[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %b, required 1", overflow); end
    send_beat(16'd14, 1'b0, 1'b0);
    send_beat(16'd15, 1'b1, 1'b0);
    for (int i = 5; i < 8; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL ovf_word%0d: got %0d after %0d waits, required %0d", i, got, waited, exp[i]);
      end
    end
  endtask

  task automatic test_full_depth;
    logic [DATA_W:0] exp [5];
    logic [DATA_W:0] got;
    int waited;
    exp = '{17'd4, 17'd20, 17'd21, 17'd22, 17'd23};
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd0;
    for (int i = 0; i < 4; i++) send_beat(16'(20 + i), (i == 3), 1'b0);
    for (int i = 0; i < 5; i++) begin
      recv_word(got, waited);
      tests_run++;
      if (got !== exp[i] || waited != 0) begin
        tests_failed++;
        $display("[TB] FAIL full_word%0d: got %0d after %0d waits, required %0d", i, got, waited, exp[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W:0] exp [4];
    logic accept;
    logic rdy;
    int idx;
    int guard;
    exp   = '{17'd3, 17'd1, 17'd2, 17'd3};
    idx   = 0;
    guard = 0;
    rdy   = 1'b0;
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd0;
    send_beat(16'd1, 1'b0, 1'b0);
    send_beat(16'd2, 1'b0, 1'b0);
    send_beat(16'd3, 1'b1, 1'b0);
    while (idx < 4 && guard < 40) begin
      tests_run++;
      if (blk_out_valid !== 1'b1 || blk_out !== exp[idx] || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_word%0d: blk_out=%0d valid=%b in_ready=%b, required %0d 1 0",
                 idx, blk_out, blk_out_valid, in_ready, exp[idx]);
      end
      blk_out_ready = rdy;
      accept        = (blk_out_valid === 1'b1) && rdy;
      @(negedge clk);
      if (accept) idx++;
      rdy = ~rdy;
      guard++;
    end
    blk_out_ready = 1'b0;
    tests_run++;
    if (idx != 4 || blk_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_end: words=%0d valid=%b, required 4 0", idx, blk_out_valid);
    end
  endtask

  task automatic test_clk_en;
    logic [DATA_W:0] got;
    int waited;
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd0;
    send_beat(16'd4, 1'b1, 1'b0);
    clk_en        = 1'b0;
    blk_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (blk_out !== 17'd1 || blk_out_valid !== 1'b1 || tx_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL clk_en_freeze: blk_out=%0d valid=%b tx_count=%0d, required 1 1 0", blk_out, blk_out_valid, tx_count);
    end
    clk_en = 1'b1;
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd1 || waited != 0) begin tests_failed++; $display("[TB] FAIL clk_en_hdr: got %0d, required 1", got); end
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd4 || waited != 0) begin tests_failed++; $display("[TB] FAIL clk_en_word: got %0d, required 4", got); end
  endtask

  task automatic test_reset_mid_drain;
    logic [DATA_W:0] got;
    int waited;
    do_flush();
    seg_mode = 1'b0;
    tx_num   = 16'd0;
    send_beat(16'd1, 1'b1, 1'b0);
    recv_word(got, waited);
    recv_word(got, waited);
    @(negedge clk);
    tests_run++;
    if (tx_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL rst_pre_count: got %0d, required 1", tx_count); end
    send_beat(16'd7, 1'b0, 1'b0);
    send_beat(16'd8, 1'b0, 1'b0);
    send_beat(16'd9, 1'b1, 1'b0);
    recv_word(got, waited);
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd7 || blk_out !== 17'd8) begin
      tests_failed++;
      $display("[TB] FAIL rst_pre_drain: got %0d next %0d, required 7 8", got, blk_out);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (blk_out_valid !== 1'b0 || blk_out !== 17'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_drain_out: valid=%b blk_out=%0d in_ready=%b, required 0 0 0", blk_out_valid, blk_out, in_ready);
    end
    tests_run++;
    if (tx_count !== 16'd0 || done !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_drain_status: tx_count=%0d done=%b overflow=%b, required 0 0 0", tx_count, done, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(16'd1, 1'b1, 1'b0);
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd1 || waited != 0) begin tests_failed++; $display("[TB] FAIL rst_refill_hdr: got %0d, required 1", got); end
    recv_word(got, waited);
    tests_run++;
    if (got !== 17'd1 || waited != 0) begin tests_failed++; $display("[TB] FAIL rst_refill_word: got %0d, required 1", got); end
    tests_run++;
    if (tx_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_count_start: got %0d, required 0", tx_count); end
    @(negedge clk);
    tests_run++;
    if (tx_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL rst_count_after: got %0d, required 1", tx_count); end
  endtask

  // Scenario sequence
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    clk_en        = 1'b1;
    flush         = 1'b0;
    seg_mode      = 1'b0;
    tx_num        = 16'd0;
    in_data       = '0;
    in_last       = 1'b0;
    in_empty      = 1'b0;
    in_valid      = 1'b0;
    blk_out_ready = 1'b0;
    test_reset();
    test_single_fiber();
    test_seg_mode();
    test_empty_crd();
    test_overflow();
    test_full_depth();
    test_back_to_back();
    test_clk_en();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
